// File: rtl/ncpu32k_wb_arbiter_pkg.sv
// ============================================================================
// Module : ncpu32k_wb_arbiter_pkg
// Purpose: Shared configuration for the writeback arbiter slice. Holds the
//          core data/register-address widths and the grant-source encoding
//          used by the arbiter's last-grant register.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ncpu32k_wb_arbiter_pkg;

  // Core-wide widths (data path and register-file address)
  localparam int NCPU_DW     = 32;
  localparam int NCPU_REG_AW = 5;

  // Writeback grant source
  typedef enum logic [0:0] {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage : ncpu32k_wb_arbiter_pkg

`default_nettype wire

// File: rtl/ncpu32k_wb_fifo.sv
// ============================================================================
// Module : ncpu32k_wb_fifo
// Purpose: Small synchronous FIFO buffering LSU writeback results so the LSU
//          never has to stall while the ALU holds the write port.
// Ports  : clk, rst_n        clock, asynchronous active-low reset
//          push, din         write request / data (ignored while full)
//          pop, dout         read request (ignored while empty) / head data
//          full, empty       status derived from the registered count
//          count             number of valid entries
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ncpu32k_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2    // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Status comes from the registered count only: a pop while full does not
  // open a slot for a push in the same cycle.
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; the count qualifies every entry.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule : ncpu32k_wb_fifo

`default_nettype wire

// File: rtl/ncpu32k_wb_arbiter.sv
// ============================================================================
// Module : ncpu32k_wb_arbiter
// Purpose: Writeback stage in front of the register file's single write port.
//          Merges back-pressurable ALU results with non-stalling LSU results
//          (buffered in a FIFO), round-robin arbitrates between them and
//          registers one write per cycle. Writes to r0 are consumed silently.
// Ports  : clk, rst_n                       clock, async active-low reset
//          alu_wb_valid/ready/addr/dat      ALU result handshake
//          lsu_wb_valid/ready/addr/dat      LSU result handshake (ready = FIFO
//                                           not full)
//          regf_we/regf_din_addr/regf_din   registered register-file write
//          wb_pending                       FIFO non-empty or write in flight
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ncpu32k_wb_arbiter
  import ncpu32k_wb_arbiter_pkg::*;
#(
  parameter int DW             = NCPU_DW,
  parameter int AW             = NCPU_REG_AW,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_wb_valid,
  output logic          alu_wb_ready,
  input  logic [AW-1:0] alu_wb_addr,
  input  logic [DW-1:0] alu_wb_dat,
  input  logic          lsu_wb_valid,
  output logic          lsu_wb_ready,
  input  logic [AW-1:0] lsu_wb_addr,
  input  logic [DW-1:0] lsu_wb_dat,
  output logic          regf_we,
  output logic [AW-1:0] regf_din_addr,
  output logic [DW-1:0] regf_din,
  output logic          wb_pending
);

  localparam int FW = AW + DW;
  localparam int CW = $clog2(LSU_FIFO_DEPTH) + 1;

  logic [FW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] fifo_addr;
  logic [DW-1:0] fifo_dat;

  logic          alu_req;
  logic          lsu_req;
  logic          grant_alu;
  logic          grant_lsu;
  wb_src_e       last_grant;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_dat;

  // --------------------------------------------------------------------------
  // LSU result buffer
  // --------------------------------------------------------------------------
  ncpu32k_wb_fifo #(
    .WIDTH (FW),
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lsu_wb_valid),
    .din   ({lsu_wb_addr, lsu_wb_dat}),
    .pop   (grant_lsu),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {fifo_addr, fifo_dat} = fifo_dout;
  assign lsu_wb_ready          = !fifo_full;

  // --------------------------------------------------------------------------
  // Round-robin arbitration: on contention the source that did not win last
  // time is granted, so neither side waits more than one cycle.
  // --------------------------------------------------------------------------
  assign alu_req = alu_wb_valid;
  assign lsu_req = !fifo_empty;

  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    sel_addr  = fifo_addr;
    sel_dat   = fifo_dat;
    if (alu_req && lsu_req) begin
      if (last_grant == WB_SRC_LSU) grant_alu = 1'b1;
      else                          grant_lsu = 1'b1;
    end else if (alu_req) begin
      grant_alu = 1'b1;
    end else if (lsu_req) begin
      grant_lsu = 1'b1;
    end
    if (grant_alu) begin
      sel_addr = alu_wb_addr;
      sel_dat  = alu_wb_dat;
    end
  end

  assign alu_wb_ready = grant_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= WB_SRC_LSU;
    end else if (grant_alu) begin
      last_grant <= WB_SRC_ALU;
    end else if (grant_lsu) begin
      last_grant <= WB_SRC_LSU;
    end
  end

  // --------------------------------------------------------------------------
  // Output register. The register file always accepts, so a grant is always
  // a completed write; an r0 destination completes the handshake but keeps
  // the write enable low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regf_we       <= 1'b0;
      regf_din_addr <= '0;
      regf_din      <= '0;
    end else if (grant_alu || grant_lsu) begin
      regf_we       <= (sel_addr != '0);
      regf_din_addr <= sel_addr;
      regf_din      <= sel_dat;
    end else begin
      regf_we       <= 1'b0;
    end
  end

  assign wb_pending = (fifo_count != '0) || regf_we;

endmodule : ncpu32k_wb_arbiter

`default_nettype wire

// File: tb/tb_ncpu32k_wb_arbiter.sv
// ============================================================================
// Module : tb_ncpu32k_wb_arbiter
// Purpose: Directed self-checking bench for ncpu32k_wb_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ncpu32k_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_wb_valid;
  logic          alu_wb_ready;
  logic [AW-1:0] alu_wb_addr;
  logic [DW-1:0] alu_wb_dat;
  logic          lsu_wb_valid;
  logic          lsu_wb_ready;
  logic [AW-1:0] lsu_wb_addr;
  logic [DW-1:0] lsu_wb_dat;
  logic          regf_we;
  logic [AW-1:0] regf_din_addr;
  logic [DW-1:0] regf_din;
  logic          wb_pending;

  int checks = 0;
  int errors = 0;

  ncpu32k_wb_arbiter #(
    .DW             (DW),
    .AW             (AW),
    .LSU_FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_ready  (alu_wb_ready),
    .alu_wb_addr   (alu_wb_addr),
    .alu_wb_dat    (alu_wb_dat),
    .lsu_wb_valid  (lsu_wb_valid),
    .lsu_wb_ready  (lsu_wb_ready),
    .lsu_wb_addr   (lsu_wb_addr),
    .lsu_wb_dat    (lsu_wb_dat),
    .regf_we       (regf_we),
    .regf_din_addr (regf_din_addr),
    .regf_din      (regf_din),
    .wb_pending    (wb_pending)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_wb_valid = 1'b0;
    alu_wb_addr  = '0;
    alu_wb_dat   = '0;
    lsu_wb_valid = 1'b0;
    lsu_wb_addr  = '0;
    lsu_wb_dat   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++; if (regf_we !== 1'b0) begin $display("FAIL reset_we: got %b want 0", regf_we); errors++; end
    checks++; if (regf_din_addr !== 5'd0) begin $display("FAIL reset_addr: got %0d want 0", regf_din_addr); errors++; end
    checks++; if (regf_din !== 32'h0) begin $display("FAIL reset_din: got %h want 0", regf_din); errors++; end
    checks++; if (lsu_wb_ready !== 1'b1) begin $display("FAIL reset_lsu_ready: got %b want 1", lsu_wb_ready); errors++; end
    checks++; if (wb_pending !== 1'b0) begin $display("FAIL reset_pending: got %b want 0", wb_pending); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_only();
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd3; alu_wb_dat = 32'hDEADBEEF;
    #1;
    checks++; if (alu_wb_ready !== 1'b1) begin $display("FAIL alu_only_ready: got %b want 1", alu_wb_ready); errors++; end
    tick();
    idle_inputs();
    checks++; if (regf_we !== 1'b1) begin $display("FAIL alu_only_we: got %b want 1", regf_we); errors++; end
    checks++; if (regf_din_addr !== 5'd3) begin $display("FAIL alu_only_addr: got %0d want 3", regf_din_addr); errors++; end
    checks++; if (regf_din !== 32'hDEADBEEF) begin $display("FAIL alu_only_din: got %h want deadbeef", regf_din); errors++; end
    tick();
    checks++; if (regf_we !== 1'b0) begin $display("FAIL alu_only_we_drop: got %b want 0", regf_we); errors++; end
  endtask

  task automatic test_lsu_only();
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd7; lsu_wb_dat = 32'h12345678;
    #1;
    checks++; if (lsu_wb_ready !== 1'b1) begin $display("FAIL lsu_only_ready: got %b want 1", lsu_wb_ready); errors++; end
    tick();
    idle_inputs();
    checks++; if (regf_we !== 1'b0) begin $display("FAIL lsu_only_we_early: got %b want 0", regf_we); errors++; end
    checks++; if (wb_pending !== 1'b1) begin $display("FAIL lsu_only_pending_c2: got %b want 1", wb_pending); errors++; end
    tick();
    checks++; if (regf_we !== 1'b1) begin $display("FAIL lsu_only_we: got %b want 1", regf_we); errors++; end
    checks++; if (regf_din_addr !== 5'd7) begin $display("FAIL lsu_only_addr: got %0d want 7", regf_din_addr); errors++; end
    checks++; if (regf_din !== 32'h12345678) begin $display("FAIL lsu_only_din: got %h want 12345678", regf_din); errors++; end
    checks++; if (wb_pending !== 1'b1) begin $display("FAIL lsu_only_pending_c3: got %b want 1", wb_pending); errors++; end
    tick();
    checks++; if (wb_pending !== 1'b0) begin $display("FAIL lsu_only_pending_end: got %b want 0", wb_pending); errors++; end
  endtask

  // Starts with last_grant = LSU and an empty FIFO.
  task automatic test_fifo_full();
    // per cycle: alu valid/addr, lsu valid/addr, expected alu_ready,
    // expected lsu_ready, expected output write after the edge
    logic       av [7] = '{0, 1, 1, 1, 0, 0, 0};
    logic [4:0] aa [7] = '{0, 4, 5, 5, 0, 0, 0};
    logic       lv [7] = '{1, 1, 1, 1, 0, 0, 0};
    logic [4:0] la [7] = '{11, 12, 13, 13, 0, 0, 0};
    logic       er [7] = '{0, 1, 0, 1, 0, 0, 0};
    logic       el [7] = '{1, 1, 0, 1, 0, 1, 1};
    logic       ew [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic [4:0] ea [7] = '{0, 4, 11, 5, 12, 13, 0};
    logic [31:0] edat;
    for (int i = 0; i < 7; i++) begin
      alu_wb_valid = av[i]; alu_wb_addr = aa[i]; alu_wb_dat = 32'hA000_0000 | 32'(aa[i]);
      lsu_wb_valid = lv[i]; lsu_wb_addr = la[i]; lsu_wb_dat = 32'hB000_0000 | 32'(la[i]);
      #1;
      checks++; if (alu_wb_ready !== er[i]) begin $display("FAIL full_alu_ready[%0d]: got %b want %b", i, alu_wb_ready, er[i]); errors++; end
      checks++; if (lsu_wb_ready !== el[i]) begin $display("FAIL full_lsu_ready[%0d]: got %b want %b", i, lsu_wb_ready, el[i]); errors++; end
      tick();
      idle_inputs();
      checks++; if (regf_we !== ew[i]) begin $display("FAIL full_we[%0d]: got %b want %b", i, regf_we, ew[i]); errors++; end
      if (ew[i]) begin
        edat = (i == 1 || i == 3) ? (32'hA000_0000 | 32'(ea[i])) : (32'hB000_0000 | 32'(ea[i]));
        checks++; if (regf_din_addr !== ea[i]) begin $display("FAIL full_addr[%0d]: got %0d want %0d", i, regf_din_addr, ea[i]); errors++; end
        checks++; if (regf_din !== edat) begin $display("FAIL full_din[%0d]: got %h want %h", i, regf_din, edat); errors++; end
      end
    end
    checks++; if (wb_pending !== 1'b0) begin $display("FAIL full_pending_end: got %b want 0", wb_pending); errors++; end
  endtask

  // Starts with last_grant = LSU: ALU wins first, then strict alternation.
  task automatic test_contention();
    logic [4:0] aa [5] = '{1, 2, 2, 3, 3};
    logic       lv [5] = '{1, 1, 0, 0, 0};
    logic [4:0] la [5] = '{9, 10, 0, 0, 0};
    logic       er [5] = '{1, 0, 1, 0, 1};
    logic [4:0] ea [5] = '{1, 9, 2, 10, 3};
    logic [31:0] edat;
    for (int i = 0; i < 5; i++) begin
      alu_wb_valid = 1'b1; alu_wb_addr = aa[i]; alu_wb_dat = 32'hA000_0000 | 32'(aa[i]);
      lsu_wb_valid = lv[i]; lsu_wb_addr = la[i]; lsu_wb_dat = 32'hB000_0000 | 32'(la[i]);
      #1;
      checks++; if (alu_wb_ready !== er[i]) begin $display("FAIL cont_alu_ready[%0d]: got %b want %b", i, alu_wb_ready, er[i]); errors++; end
      tick();
      idle_inputs();
      edat = er[i] ? (32'hA000_0000 | 32'(ea[i])) : (32'hB000_0000 | 32'(ea[i]));
      checks++; if (regf_we !== 1'b1) begin $display("FAIL cont_we[%0d]: got %b want 1", i, regf_we); errors++; end
      checks++; if (regf_din_addr !== ea[i]) begin $display("FAIL cont_addr[%0d]: got %0d want %0d", i, regf_din_addr, ea[i]); errors++; end
      checks++; if (regf_din !== edat) begin $display("FAIL cont_din[%0d]: got %h want %h", i, regf_din, edat); errors++; end
    end
    tick();
    checks++; if (regf_we !== 1'b0) begin $display("FAIL cont_we_end: got %b want 0", regf_we); errors++; end
  endtask

  // Starts with last_grant = LSU. An LSU entry is parked in the FIFO so that
  // the grant after the r0 write reveals whether last_grant moved to ALU.
  task automatic test_r0_drop();
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd20; lsu_wb_dat = 32'h0000_0020;
    tick();
    idle_inputs();
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd0; alu_wb_dat = 32'hFFFFFFFF;
    #1;
    checks++; if (alu_wb_ready !== 1'b1) begin $display("FAIL r0_ready: got %b want 1", alu_wb_ready); errors++; end
    tick();
    checks++; if (regf_we !== 1'b0) begin $display("FAIL r0_we: got %b want 0", regf_we); errors++; end
    alu_wb_addr = 5'd6; alu_wb_dat = 32'h0000_0006;
    #1;
    checks++; if (alu_wb_ready !== 1'b0) begin $display("FAIL r0_last_grant: alu_ready got %b want 0", alu_wb_ready); errors++; end
    tick();
    checks++; if (regf_we !== 1'b1 || regf_din_addr !== 5'd20) begin $display("FAIL r0_next_lsu: we=%b addr=%0d want we=1 addr=20", regf_we, regf_din_addr); errors++; end
    tick();
    idle_inputs();
    checks++; if (regf_we !== 1'b1 || regf_din_addr !== 5'd6) begin $display("FAIL r0_next_alu: we=%b addr=%0d want we=1 addr=6", regf_we, regf_din_addr); errors++; end
    tick();
  endtask

  // Starts with last_grant = ALU and an empty FIFO.
  task automatic test_reset_mid();
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd21; lsu_wb_dat = 32'h21;
    tick();
    lsu_wb_addr = 5'd22; lsu_wb_dat = 32'h22;
    tick();
    lsu_wb_addr = 5'd23; lsu_wb_dat = 32'h23;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd9; alu_wb_dat = 32'h9;
    tick();
    idle_inputs();
    checks++; if (regf_we !== 1'b1 || lsu_wb_ready !== 1'b0) begin $display("FAIL mid_setup: we=%b lsu_ready=%b want we=1 lsu_ready=0", regf_we, lsu_wb_ready); errors++; end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (regf_we !== 1'b0) begin $display("FAIL mid_async_we: got %b want 0", regf_we); errors++; end
    checks++; if (wb_pending !== 1'b0) begin $display("FAIL mid_async_pending: got %b want 0", wb_pending); errors++; end
    tick();
    #1;
    rst_n = 1'b1;
    checks++; if (lsu_wb_ready !== 1'b1) begin $display("FAIL mid_lsu_ready: got %b want 1", lsu_wb_ready); errors++; end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (regf_we !== 1'b0 || wb_pending !== 1'b0) begin $display("FAIL mid_stale[%0d]: we=%b pending=%b want 0 0", i, regf_we, wb_pending); errors++; end
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_lsu_only();
    test_fifo_full();
    test_contention();
    test_lsu_only();
    test_r0_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ncpu32k_wb_arbiter

`default_nettype wire
